// File: rtl/coherent_bus_arbiter.sv
// Round-robin arbiter and broadcast hub for an N-core MSI snooping bus.
// Optional GRANT_TIMEOUT_EN: force-release an owner that idles in GRANTED for TIMEOUT cycles.
module coherent_bus_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int SNOOP_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_core,
  input  logic [NUM_CORES*DATA_W-1:0]   bus_data_out,
  input  logic [NUM_CORES*ADDR_W-1:0]   bus_address_out,
  input  logic [NUM_CORES*2-1:0]        bus_operation_out,
  input  logic [NUM_CORES-1:0]          cache_hit_out,
  output logic [NUM_CORES-1:0]          grant,
  output logic [DATA_W-1:0]             bus_data_in,
  output logic [ADDR_W-1:0]             bus_address_in,
  output logic [1:0]                    bus_operation_in,
  output logic [NUM_CORES-1:0]          cache_hit_in,
  output logic                          hit_valid,
  output logic [$clog2(NUM_CORES)-1:0]  owner_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_CORES);
  localparam int SCW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
  localparam logic [1:0] OP_NON = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANTED = 2'b01,
    ST_SNOOP   = 2'b10,
    ST_HOLD    = 2'b11
  } state_t;

  state_t                 state_r, state_s;
  logic [NUM_CORES-1:0]   grant_r, grant_s;
  logic [DATA_W-1:0]      data_r, data_s;
  logic [ADDR_W-1:0]      addr_r, addr_s;
  logic [1:0]             op_r, op_s;
  logic [NUM_CORES-1:0]   hit_r, hit_s;
  logic                   hv_r, hv_s;
  logic [IDW-1:0]         owner_r, owner_s;
  logic                   busy_r, busy_s;
  logic [IDW-1:0]         rr_ptr_r, rr_ptr_s;
  logic [SCW-1:0]         snoop_cnt_r, snoop_cnt_s;
  logic                   release_s;
  logic [IDW-1:0]         win_s;
  logic [1:0]             owner_op_s;
  logic                   owner_req_s;

`ifdef GRANT_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT) + 1;
  logic [TOW-1:0]         to_cnt_r, to_cnt_s;
`endif

  // First requester at or above ptr, wrapping with an explicit compare (NUM_CORES need not be 2^n).
  function automatic logic [IDW-1:0] pick_winner(input logic [NUM_CORES-1:0] req,
                                                 input logic [IDW-1:0] ptr);
    logic [IDW:0]   cand;
    logic [IDW-1:0] idx;
    idx = ptr;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      cand = (cand >= (IDW+1)'(NUM_CORES)) ? (cand - (IDW+1)'(NUM_CORES)) : cand;
      idx  = req[cand[IDW-1:0]] ? cand[IDW-1:0] : idx;
    end
    return idx;
  endfunction

  // Owner-side request/operation and round-robin winner.
  always_comb begin
    win_s       = pick_winner(req_core, rr_ptr_r);
    owner_op_s  = bus_operation_out[owner_r*2 +: 2];
    owner_req_s = req_core[owner_r];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    data_s      = data_r;
    addr_s      = addr_r;
    op_s        = op_r;
    hit_s       = hit_r;
    hv_s        = 1'b0;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    snoop_cnt_s = snoop_cnt_r;
    release_s   = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    to_cnt_s    = to_cnt_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (|req_core) begin
          grant_s = {{(NUM_CORES-1){1'b0}}, 1'b1} << win_s;
          owner_s = win_s;
          state_s = ST_GRANTED;
`ifdef GRANT_TIMEOUT_EN
          to_cnt_s = '0;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (owner_op_s != OP_NON) begin
          data_s      = bus_data_out[owner_r*DATA_W +: DATA_W];
          addr_s      = bus_address_out[owner_r*ADDR_W +: ADDR_W];
          op_s        = owner_op_s;
          snoop_cnt_s = SCW'(SNOOP_CYCLES - 1);
          state_s     = ST_SNOOP;
        end else if (!owner_req_s) begin
          release_s = 1'b1;
`ifdef GRANT_TIMEOUT_EN
        end else if (to_cnt_r == TOW'(TIMEOUT - 1)) begin
          release_s = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r + TOW'(1);
`else
        end else begin
          state_s = ST_GRANTED;
`endif
        end
      end
      ST_SNOOP: begin
        if (snoop_cnt_r == SCW'(0)) begin
          hit_s   = cache_hit_out & ~grant_r;
          hv_s    = 1'b1;
          state_s = ST_HOLD;
        end else begin
          snoop_cnt_s = snoop_cnt_r - SCW'(1);
        end
      end
      ST_HOLD: begin
        if (!owner_req_s) begin
          release_s = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (release_s) begin
      grant_s  = '0;
      op_s     = OP_NON;
      data_s   = '0;
      addr_s   = '0;
      rr_ptr_s = (owner_r == IDW'(NUM_CORES - 1)) ? IDW'(0) : (owner_r + IDW'(1));
      state_s  = ST_IDLE;
    end else begin
      rr_ptr_s = rr_ptr_r;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      grant_r     <= '0;
      data_r      <= '0;
      addr_r      <= '0;
      op_r        <= OP_NON;
      hit_r       <= '0;
      hv_r        <= 1'b0;
      owner_r     <= '0;
      busy_r      <= 1'b0;
      rr_ptr_r    <= '0;
      snoop_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      data_r      <= data_s;
      addr_r      <= addr_s;
      op_r        <= op_s;
      hit_r       <= hit_s;
      hv_r        <= hv_s;
      owner_r     <= owner_s;
      busy_r      <= busy_s;
      rr_ptr_r    <= rr_ptr_s;
      snoop_cnt_r <= snoop_cnt_s;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Idle-grant timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_s;
    end
  end
`endif

  assign grant            = grant_r;
  assign bus_data_in      = data_r;
  assign bus_address_in   = addr_r;
  assign bus_operation_in = op_r;
  assign cache_hit_in     = hit_r;
  assign hit_valid        = hv_r;
  assign owner_id         = owner_r;
  assign busy             = busy_r;

endmodule

// File: doc/coherent_bus_arbiter.md
Name: coherent_bus_arbiter

Overview:
- Parametrised N-core arbiter and broadcast hub for the shared snooping bus (MSI-style ops: BusRd=2'b00, BusUpgr=2'b01, BusRdX=2'b10, BusNoN=2'b11).
- Grants the bus round-robin to one core's req_core and registers that core's transaction.
- Broadcasts the transaction to all cores, collects snoop hits from the non-owners, and releases the bus when the owner drops its request.
- Replaces point-to-point two-core bus wiring; sits between the per-core Processor instances and L2.

Parameters:
NUM_CORES, 4, number of attached cores (2..16)
DATA_W, 32, bus data width
ADDR_W, 32, bus address width
SNOOP_CYCLES, 2, cycles the broadcast is held before hits are sampled (>=1)
TIMEOUT, 64, idle-grant cycles before forced release (only with GRANT_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_core  in  NUM_CORES  per-core bus request
bus_data_out  in  NUM_CORES*DATA_W  per-core data, core i at [i*DATA_W +: DATA_W]
bus_address_out  in  NUM_CORES*ADDR_W  per-core address, packed the same way
bus_operation_out  in  NUM_CORES*2  per-core operation, core i at [2i+:2]
cache_hit_out  in  NUM_CORES  per-core snoop hit
grant  out  NUM_CORES  one-hot grant (or zero)
bus_data_in  out  DATA_W  broadcast data
bus_address_in  out  ADDR_W  broadcast address
bus_operation_in  out  2  broadcast operation
cache_hit_in  out  NUM_CORES  registered snoop-hit vector; owner bit forced 0
hit_valid  out  1  one-cycle pulse when cache_hit_in is updated
owner_id  out  $clog2(NUM_CORES)  index of current/last owner
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: grant=0, bus_data_in=0, bus_address_in=0, bus_operation_in=2'b11, cache_hit_in=0, hit_valid=0, owner_id=0, busy=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-transaction returns everything to reset values on that edge; no partial broadcast is retained.
- All outputs are registered.
- States: IDLE, GRANTED, SNOOP, HOLD.
- IDLE:
  - If req_core!=0, pick the first requester searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... mod NUM_CORES).
  - Next edge: grant one-hot to the winner, owner_id=winner, go to GRANTED.
  - Grant latency from req seen = 1 cycle.
- GRANTED:
  - If the owner's op != 2'b11, latch its address, data and op into the bus_*_in registers and go to SNOOP; the snoop counter loads SNOOP_CYCLES-1.
  - Else if req_core[owner]==0, go to release.
- SNOOP:
  - Broadcast registers held stable; counter decrements.
  - At 0: cache_hit_in = cache_hit_out with the owner bit cleared; hit_valid=1 for one cycle; go to HOLD.
- HOLD:
  - Broadcast registers held.
  - When req_core[owner]==0, go to release.
- Release (one edge):
  - grant=0, bus_operation_in=2'b11, data/address zeroed.
  - rr_ptr=(owner+1) mod NUM_CORES; state=IDLE.
  - The next grant is earliest 2 edges after the drop is sampled, so there is never a grant-to-grant overlap.
- Changes on the owner's inputs after latching are ignored; the broadcast reflects the value sampled in GRANTED.
- Non-owner requests are ignored while busy; they stay pending and the bench must keep them asserted.
- Owner dropping req during SNOOP: the SNOOP sequence completes (hit_valid still pulses), then release occurs directly from HOLD on the next edge.
- cache_hit_in holds its value until the next hit_valid or reset.
- NUM_CORES not a power of 2: the rr_ptr wrap uses an explicit compare, never truncation.

Optional Feature:
- Macro GRANT_TIMEOUT_EN.
- Defined:
  - A counter runs in GRANTED while the owner's op==2'b11.
  - On reaching TIMEOUT cycles, a forced release occurs regardless of req_core; hit_valid does not pulse.
  - The counter clears on entry to GRANTED.
- Undefined: no counter is present and GRANTED waits indefinitely.

Test Plan:
- NUM_CORES=4, reset held 2 cycles -> all outputs at reset values, bus_operation_in=2'b11.
- Core 2 requests alone, op=2'b00, addr=0x0000_0040 -> grant=4'b0100 one edge later; broadcast addr 0x40 with op 00; after SNOOP_CYCLES, hit_valid pulses with cache_hit_in=4'b1000 when core 3 hits.
- Cores 0,1,3 request continuously, each dropping after its op -> grant order 0,1,3,0; no two grant bits set simultaneously; at least one zero-grant cycle between owners.
- Owner 1 drives BusRdX 0x100, sets its own cache_hit_out=1 with core 0 hit=1 -> cache_hit_in=4'b0001 (owner bit masked).
- Reset asserted in SNOOP -> next edge grant=0, op=2'b11, hit_valid=0, rr_ptr=0.
- GRANT_TIMEOUT_EN with TIMEOUT=8: owner holds req with op=2'b11 -> grant drops after 8 GRANTED cycles, no hit_valid, next requester granted.
